receptor_serial: RTL and testbench

- Serial receive stage directly upstream of modulo_top: deserializes the transmitted Hamming(8,4) codeword from a single line and produces the 8-bit palabra_rx consumed by the decoder/display stage.
- Frame format: UART-style, idle-high line, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), fixed bit period in clock cycles.
- palabra_rx holds the last good frame between frames, so the decoder and displays see a stable word.

---
 rtl/receptor_serial.sv | 113 +++++++++++
 tb/tb_receptor_serial.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/receptor_serial.sv
// UART-style receiver for the Hamming(8,4) codeword feeding modulo_top.
// Idle-high line, 1 start bit, 8 data bits LSB first, 1 stop bit, fixed bit period.
module receptor_serial #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] palabra_rx,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy,
  output logic [3:0] err_count
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign busy = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= ST_WAIT_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      palabra_rx  <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      err_count   <= '0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (!rx_s) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_START;
          end
        end

        // A line that is high again at mid start bit was only a glitch.
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Returning to IDLE right at the stop sample lets a back-to-back
        // frame's start edge be caught within the remaining half stop bit.
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              palabra_rx <= shreg;
              rx_valid   <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              frame_error <= 1'b1;
              if (err_count != 4'hF) err_count <= err_count + 1'b1;
              state <= ST_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_serial.sv
// Bench for receptor_serial: drives serial line waveforms cycle by cycle and
// checks every output each cycle against a frame-level timing model.
module tb_receptor_serial;

  localparam int CPB      = 16;
  localparam int EV_START = 3 + CPB / 2;            // edge of the start-bit sample
  localparam int EV_FRAME = 3 + CPB / 2 + 9 * CPB;  // edge of the stop-bit sample

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] palabra_rx;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;
  logic [3:0] err_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_pal = 8'h00;
  logic [3:0] m_err = 4'h0;
  logic       line_q[$];

  always #5 clk = ~clk;

  receptor_serial #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .palabra_rx (palabra_rx),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .busy       (busy),
    .err_count  (err_count)
  );

  task automatic check(input string tag, input int c, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  task automatic check_all(input int c, input logic e_busy, input logic e_valid,
                           input logic e_ferr, input logic [7:0] e_pal, input logic [3:0] e_err);
    check("busy", c, {7'd0, busy}, {7'd0, e_busy});
    check("rx_valid", c, {7'd0, rx_valid}, {7'd0, e_valid});
    check("frame_error", c, {7'd0, frame_error}, {7'd0, e_ferr});
    check("palabra_rx", c, palabra_rx, e_pal);
    check("err_count", c, {4'd0, err_count}, {4'd0, e_err});
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // outcome: 0 none, 1 good frame, 2 framing error; ev_c = edge of the deciding sample (0: no start)
  task automatic play(input int ev_c, input int outcome, input logic [7:0] data);
    for (int c = 0; c < line_q.size(); c++) begin
      logic past;
      @(negedge clk);
      past = (ev_c > 0) && (c >= ev_c);
      check_all(c,
                (ev_c > 0) && (c >= 3) && (c < ev_c),
                (outcome == 1) && (c == ev_c),
                (outcome == 2) && (c == ev_c),
                ((outcome == 1) && past) ? data : m_pal,
                ((outcome == 2) && past) ? sat_inc(m_err) : m_err);
      rx = line_q[c];
    end
    if (outcome == 1) m_pal = data;
    if (outcome == 2) m_err = sat_inc(m_err);
    line_q.delete();
    $display("[TB] seq outcome=%0d data=%02h pal=%02h err=%0d", outcome, data, palabra_rx, err_count);
  endtask

  task automatic build_frame(input logic [7:0] data, input logic stop, input int low_after, input int gap);
    for (int i = 0; i < CPB; i++) line_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) line_q.push_back(data[k]);
    for (int i = 0; i < CPB; i++) line_q.push_back(stop);
    for (int i = 0; i < low_after; i++) line_q.push_back(1'b0);
    for (int i = 0; i < gap; i++) line_q.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int low_after, input int gap);
    build_frame(data, stop, low_after, gap);
    play(EV_FRAME, stop ? 1 : 2, data);
  endtask

  task automatic glitch(input int len);
    for (int i = 0; i < len; i++) line_q.push_back(1'b0);
    for (int i = 0; i < 14; i++) line_q.push_back(1'b1);
    play(EV_START, 0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(1'b1);
    play(0, 0, 8'h00);
  endtask

  initial begin
    // power-on reset
    repeat (2) @(negedge clk);
    check_all(-1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    rst_n = 1'b1;
    idle(50);

    // directed frames
    send_frame(8'hD2, 1'b1, 0, 5);
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 4);
    send_frame(8'hA5, 1'b0, 40, 6);
    send_frame(8'h3C, 1'b1, 0, 3);
    glitch(5);

    // randomized traffic
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, 7)));
      if (s) send_frame(d, 1'b1, 0, int'($urandom_range(0, 8)));
      else   send_frame(d, 1'b0, int'($urandom_range(0, 20)), int'($urandom_range(2, 8)));
    end

    // reset asserted during data bit 4 of a frame whose upper bits are all ones
    build_frame(8'hF0, 1'b1, 0, 10);
    for (int c = 0; c < line_q.size(); c++) begin
      @(negedge clk);
      check_all(c, (c >= 3) && (c <= 85), 1'b0, 1'b0, m_pal, m_err);
      if (c == 85) begin
        rst_n = 1'b0;
        #1;
        check_all(c, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        m_pal = 8'h00;
        m_err = 4'h0;
      end
      if (c == 89) rst_n = 1'b1;
      rx = line_q[c];
    end
    line_q.delete();
    $display("[TB] reset mid-frame pal=%02h err=%0d", palabra_rx, err_count);

    // error counter saturation
    for (int n = 0; n < 16; n++) send_frame(8'($urandom), 1'b0, 0, 3);
    @(negedge clk);
    check("err_sat", 0, {4'd0, err_count}, 8'h0F);
    send_frame(8'h5A, 1'b1, 0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
